// File: rtl/serial_pkg.sv
// serial_pkg: shared serial-line FSM states and line constants
package serial_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: loadable right-shift register exposing its LSB
module piso_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             lsb
);
  logic [WIDTH-1:0] q;
  always_ff @(posedge clk)
    q <= rst ? '0 : load ? d : shift ? q >> 1 : q;
  assign lsb = q[0];
endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out framer (start bit, LSB-first data, stop bits)
module piso_tx
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             busy,
  output logic             frame_done
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t          state, nxt;
  logic [CW-1:0]   cnt;
  logic            stop_cnt, armed, accept, last_stop, lsb;
  assign last_stop  = state == STOP && stop_cnt == 1'(STOP_BITS - 1);
  assign din_ready  = armed && (state == IDLE || last_stop);
  assign accept     = din_valid && din_ready;
  assign busy       = state != IDLE;
  assign frame_done = last_stop;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? START : IDLE;
      START:   nxt = DATA;
      DATA:    nxt = cnt == CW'(WIDTH - 1) ? STOP : DATA;
      default: nxt = last_stop ? (accept ? START : IDLE) : STOP;
    endcase
  end
  // so is loaded with the bit for the upcoming state, so the shifter advances on DATA entry too
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      stop_cnt <= 1'b0;
      armed    <= 1'b0;
      so       <= LINE_IDLE;
    end else begin
      state    <= nxt;
      cnt      <= state == DATA ? cnt + CW'(1) : '0;
      stop_cnt <= state == STOP && nxt == STOP ? stop_cnt + 1'b1 : 1'b0;
      armed    <= 1'b1;
      so       <= nxt == START ? 1'b0 : nxt == DATA ? lsb : LINE_IDLE;
    end
  end
  piso_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (nxt == DATA),
    .d     (din),
    .lsb   (lsb)
  );
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed checks of piso_tx framing, back-to-back, reset and stop-bit variants
module tb_piso_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready, so, busy, frame_done;
  logic [3:0] din2 = '0;
  logic       din_valid2 = 1'b0;
  logic       din_ready2, so2, busy2, frame_done2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .so(so), .busy(busy), .frame_done(frame_done)
  );

  piso_tx #(.WIDTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .din(din2), .din_valid(din_valid2),
    .din_ready(din_ready2), .so(so2), .busy(busy2), .frame_done(frame_done2)
  );

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({so, busy, din_ready, frame_done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state got so/busy/rdy/fd=%b exp 1000", {so, busy, din_ready, frame_done});
    end
    checks++;
    if ({so2, busy2, din_ready2, frame_done2} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state2 got so/busy/rdy/fd=%b exp 1000", {so2, busy2, din_ready2, frame_done2});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b exp 1", din_ready);
    end
  endtask

  task automatic test_single;
    logic [9:0] e;
    e = {1'b1, 8'hA5, 1'b0};
    din = 8'hA5;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (so !== e[i] || busy !== 1'b1 || frame_done !== (i == 9)) begin
        errors++;
        $display("FAIL single_T%0d got so=%b busy=%b fd=%b exp so=%b busy=1 fd=%b", i + 1, so, busy, frame_done, e[i], i == 9);
      end
      if (i == 9) begin
        checks++;
        if (din_ready !== 1'b1) begin
          errors++;
          $display("FAIL single_ready_T10 got %b exp 1", din_ready);
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({so, busy, frame_done} !== 3'b100) begin
      errors++;
      $display("FAIL single_idle got so/busy/fd=%b exp 100", {so, busy, frame_done});
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] e;
    int pulses;
    e = {1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0};
    pulses = 0;
    din = 8'h3C;
    din_valid = 1'b1;
    @(negedge clk);
    din = 8'hC3;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) din_valid = 1'b0;
      if (frame_done === 1'b1) pulses++;
      checks++;
      if (so !== e[i] || busy !== 1'b1 || frame_done !== (i == 9 || i == 19)) begin
        errors++;
        $display("FAIL b2b_T%0d got so=%b busy=%b fd=%b exp so=%b busy=1 fd=%b", i + 1, so, busy, frame_done, e[i], i == 9 || i == 19);
      end
      @(negedge clk);
    end
    checks++;
    if (pulses !== 2 || busy !== 1'b0 || so !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end got pulses=%0d busy=%b so=%b exp pulses=2 busy=0 so=1", pulses, busy, so);
    end
  endtask

  task automatic test_busy_din;
    din = 8'h00;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din = 8'hFF;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (so !== 1'b0) begin
        errors++;
        $display("FAIL busy_din_bit%0d got %b exp 0", i, so);
      end
      @(negedge clk);
    end
    checks++;
    if (so !== 1'b1 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL busy_din_stop got so=%b fd=%b exp so=1 fd=1", so, frame_done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    din = 8'h00;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (so !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_bit3 got so=%b busy=%b exp so=0 busy=1", so, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({so, busy, din_ready, frame_done} !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_abort got so/busy/rdy/fd=%b exp 1000", {so, busy, din_ready, frame_done});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready got %b exp 1", din_ready);
    end
    for (int i = 0; i < 8; i++) begin
      if (frame_done !== 1'b0 || so !== 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL rstmid_quiet got %0d bad cycles exp 0", pulses);
    end
  endtask

  task automatic test_stop2;
    logic [6:0] e;
    e = {2'b11, 4'h9, 1'b0};
    din2 = 4'h9;
    din_valid2 = 1'b1;
    @(negedge clk);
    din_valid2 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (so2 !== e[i] || busy2 !== 1'b1 || frame_done2 !== (i == 6)) begin
        errors++;
        $display("FAIL stop2_T%0d got so=%b busy=%b fd=%b exp so=%b busy=1 fd=%b", i + 1, so2, busy2, frame_done2, e[i], i == 6);
      end
      @(negedge clk);
    end
    checks++;
    if ({so2, busy2, frame_done2, din_ready2} !== 4'b1001) begin
      errors++;
      $display("FAIL stop2_idle got so/busy/fd/rdy=%b exp 1001", {so2, busy2, frame_done2, din_ready2});
    end
  endtask

  task automatic test_rst_accept;
    int bad;
    bad = 0;
    din = 8'h55;
    din_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (so !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rst_accept got %0d cycles with start/busy exp 0", bad);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_busy_din;
    test_reset_mid;
    test_stop2;
    test_rst_accept;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of data bits per frame (legal range 1..32).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning the number of stop-bit cycles per frame (legal values 1 or 2).
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port din, input, WIDTH, parallel word to transmit.
REQ-006 SHALL have port din_valid, input, 1, meaning din holds a word to send.
REQ-007 SHALL have port din_ready, output, 1, meaning the block can accept a word this cycle.
REQ-008 SHALL have port so, output, 1, registered serial line output (idle level 1).
REQ-009 SHALL have port busy, output, 1, meaning a frame is in progress (start, data or stop).
REQ-010 SHALL have port frame_done, output, 1, a one-cycle pulse in the final stop-bit cycle.

Function
REQ-011 SHALL accept a word only on a rising edge where din_valid and din_ready are both 1, capturing din into an internal shift register.
REQ-012 SHALL ignore din and din_valid on every edge where din_ready is 0; a change on din while busy SHALL NOT alter the frame in flight.
REQ-013 SHALL implement the FSM states IDLE, START, DATA and STOP, with the following transitions:
- IDLE->START on accept.
- START->DATA after 1 cycle.
- DATA->STOP after WIDTH cycles.
- STOP->IDLE after STOP_BITS cycles with no accept.
- STOP->START on an accept in the last stop cycle.
REQ-014 SHALL drive so=1 in IDLE, so=0 for 1 cycle in START, data bits LSB first in DATA (one bit per cycle, shifting right), and so=1 in STOP.
REQ-015 SHALL make the start bit visible on so in the cycle immediately following the accepting edge, giving a latency of 1 cycle.
REQ-016 SHALL make each frame exactly 1+WIDTH+STOP_BITS cycles long.
REQ-017 SHALL drive din_ready=1 in IDLE and in the last STOP cycle, and 0 otherwise.
REQ-018 SHALL, when din_valid is held continuously, start the next frame back-to-back with no idle cycle between frames.
REQ-019 SHALL track DATA progress with a bit counter of width clog2(WIDTH+1) that is cleared on entry to DATA; the counter SHALL NOT wrap within a frame.
REQ-020 SHALL drive busy=1 in START, DATA and STOP, and 0 in IDLE.
REQ-021 SHALL assert frame_done for exactly one cycle, in the final STOP cycle, and SHALL also do so on back-to-back frames.
REQ-022 SHALL have rst take priority over a simultaneous accept; the offered word SHALL be dropped.

Reset
REQ-023 SHALL, on any edge where rst=1, set the state to IDLE, so=1, din_ready=0, busy=0, frame_done=0, and clear the shift register and counter.
REQ-024 SHALL drive din_ready=1 in the first cycle after rst is sampled 0.
REQ-025 SHALL, when rst is asserted mid-frame, abort the frame with so=1 in the next cycle; there SHALL be no partial stop bit and no frame_done pulse.

Structure
REQ-026 SHALL take the FSM state enum (IDLE/START/DATA/STOP) and the constant LINE_IDLE=1 from the shared package serial_pkg.
REQ-027 SHALL contain exactly one sub-module, piso_shreg (parameterized WIDTH, with load, shift-right and LSB-out functions); the FSM and counter SHALL stay in piso_tx.

Verification
REQ-028 SHALL be verified for single frame: WIDTH=8, din=8'hA5 accepted at T0 -> so over T1..T10 = 0,1,0,1,0,0,1,0,1,1; frame_done high at T10 only; din_ready=1 at T10.
REQ-029 SHALL be verified for back-to-back: 8'h3C then 8'hC3 with din_valid held -> 20 consecutive frame cycles, second start bit at T11 with no idle gap, and two frame_done pulses.
REQ-030 SHALL be verified for busy-time stimulus: din toggled to 8'hFF during the DATA phase of an 8'h00 frame -> all eight data bits = 0.
REQ-031 SHALL be verified for reset mid-frame: rst=1 after the 3rd data bit -> so=1, busy=0 and din_ready=0 the next cycle, din_ready=1 one cycle after release, and no frame_done.
REQ-032 SHALL be verified for STOP_BITS=2, WIDTH=4, din=4'h9 -> so = 0,1,0,0,1,1,1 (7 cycles), with frame_done in cycle 7 only.
REQ-033 SHALL be verified for simultaneous rst and accept: din=8'h55 -> no start bit, and so stays 1.
